// File: rtl/div_neg_cell.sv
// div_neg_cell: conditional two's-complement negator bit (XOR then half adder).
module div_neg_cell (
  input  logic a,
  input  logic inv,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic x;
  always_comb begin
    x    = a ^ inv;
    sum  = x ^ cin;
    cout = x & cin;
  end
endmodule

// File: rtl/div_bitslice.sv
// div_bitslice: one bit of a bit-serial divider datapath; N slices abut to form an N-bit divider.
module div_bitslice (
  input  logic Clock,
  input  logic nReset,
  input  logic Test,
  input  logic SDI,
  input  logic Operand1,
  input  logic Operand2,
  input  logic INV_OP1,
  input  logic INV_OP2,
  input  logic OP1_INV_Cin,
  input  logic OP2_INV_Cin,
  output logic OP1_INV_Cout,
  output logic OP2_INV_Cout,
  input  logic DIVL_P,
  input  logic LOAD_DIVL,
  output logic DIVL_1,
  input  logic DIVH_P,
  input  logic LOAD_DIVH,
  output logic DIVH_1,
  output logic DIVH_0,
  input  logic DIVH_0_P,
  input  logic ACC_Cin,
  output logic ACC_Cout,
  input  logic LOAD_ACC,
  input  logic STORE_ACC,
  input  logic INV_REM,
  input  logic ACC_INV_Cin,
  output logic ACC_INV_Cout,
  input  logic STORE_REM,
  output logic Remainder,
  input  logic RESULT_P,
  input  logic RESULT_nP_0,
  output logic RESULT_1,
  input  logic INV_RESULT,
  input  logic RESULT_INV_Cin,
  output logic RESULT_INV_Cout,
  input  logic STORE_QUOT,
  output logic Quotient
);
  logic ACC_Q, divl_q, divh_q, result_q, quot_q, rem_q;
  logic acc_d, divl_d, divh_d, result_d, quot_d, rem_d;
  logic op1_sum, op2_sum, rem_sum, res_sum, acc_s;
  div_neg_cell u_op1 (.a(Operand1), .inv(INV_OP1), .cin(OP1_INV_Cin), .sum(op1_sum), .cout(OP1_INV_Cout));
  div_neg_cell u_op2 (.a(Operand2), .inv(INV_OP2), .cin(OP2_INV_Cin), .sum(op2_sum), .cout(OP2_INV_Cout));
  div_neg_cell u_rem (.a(ACC_Q), .inv(INV_REM), .cin(ACC_INV_Cin), .sum(rem_sum), .cout(ACC_INV_Cout));
  div_neg_cell u_res (.a(result_q), .inv(INV_RESULT), .cin(RESULT_INV_Cin), .sum(res_sum), .cout(RESULT_INV_Cout));
  // Test muxes come first so scan overrides every load select and enable
  always_comb begin
    acc_s    = ACC_Q ^ DIVH_0_P ^ ACC_Cin;
    ACC_Cout = (ACC_Q & DIVH_0_P) | (ACC_Q & ACC_Cin) | (DIVH_0_P & ACC_Cin);
    acc_d    = Test ? SDI : STORE_ACC ? (LOAD_ACC ? op1_sum : acc_s) : ACC_Q;
    divl_d   = Test ? ACC_Q : LOAD_DIVL ? op1_sum : DIVL_P;
    divh_d   = Test ? divl_q : LOAD_DIVH ? op2_sum : DIVH_P;
    result_d = Test ? divh_q : RESULT_nP_0 ? 1'b0 : RESULT_P;
    quot_d   = Test ? result_q : STORE_QUOT ? res_sum : quot_q;
    rem_d    = Test ? quot_q : STORE_REM ? rem_sum : rem_q;
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ACC_Q    <= 1'b0;
      divl_q   <= 1'b0;
      divh_q   <= 1'b0;
      result_q <= 1'b0;
      quot_q   <= 1'b0;
      rem_q    <= 1'b0;
    end else begin
      ACC_Q    <= acc_d;
      divl_q   <= divl_d;
      divh_q   <= divh_d;
      result_q <= result_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end
  assign DIVL_1    = divl_q;
  assign DIVH_1    = divh_q;
  assign DIVH_0    = ~divh_q;
  assign RESULT_1  = result_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
endmodule

// File: tb/tb_div_bitslice.sv
// tb_div_bitslice: directed self-checking bench for one divider bit slice.
module tb_div_bitslice;
  logic Clock = 1'b0, nReset = 1'b0, Test = 1'b0, SDI = 1'b0;
  logic Operand1 = 1'b0, Operand2 = 1'b0, INV_OP1 = 1'b0, INV_OP2 = 1'b0;
  logic OP1_INV_Cin = 1'b0, OP2_INV_Cin = 1'b0, OP1_INV_Cout, OP2_INV_Cout;
  logic DIVL_P = 1'b0, LOAD_DIVL = 1'b0, DIVL_1;
  logic DIVH_P = 1'b0, LOAD_DIVH = 1'b0, DIVH_1, DIVH_0, DIVH_0_P = 1'b0;
  logic ACC_Cin = 1'b0, ACC_Cout, LOAD_ACC = 1'b0, STORE_ACC = 1'b0;
  logic INV_REM = 1'b0, ACC_INV_Cin = 1'b0, ACC_INV_Cout, STORE_REM = 1'b0, Remainder;
  logic RESULT_P = 1'b0, RESULT_nP_0 = 1'b0, RESULT_1, INV_RESULT = 1'b0;
  logic RESULT_INV_Cin = 1'b0, RESULT_INV_Cout, STORE_QUOT = 1'b0, Quotient;
  int errors = 0, checks = 0;
  logic sb[$];
  logic [5:0] pat;

  div_bitslice dut (
    .Clock(Clock), .nReset(nReset), .Test(Test), .SDI(SDI),
    .Operand1(Operand1), .Operand2(Operand2), .INV_OP1(INV_OP1), .INV_OP2(INV_OP2),
    .OP1_INV_Cin(OP1_INV_Cin), .OP2_INV_Cin(OP2_INV_Cin),
    .OP1_INV_Cout(OP1_INV_Cout), .OP2_INV_Cout(OP2_INV_Cout),
    .DIVL_P(DIVL_P), .LOAD_DIVL(LOAD_DIVL), .DIVL_1(DIVL_1),
    .DIVH_P(DIVH_P), .LOAD_DIVH(LOAD_DIVH), .DIVH_1(DIVH_1), .DIVH_0(DIVH_0),
    .DIVH_0_P(DIVH_0_P), .ACC_Cin(ACC_Cin), .ACC_Cout(ACC_Cout),
    .LOAD_ACC(LOAD_ACC), .STORE_ACC(STORE_ACC), .INV_REM(INV_REM),
    .ACC_INV_Cin(ACC_INV_Cin), .ACC_INV_Cout(ACC_INV_Cout), .STORE_REM(STORE_REM),
    .Remainder(Remainder), .RESULT_P(RESULT_P), .RESULT_nP_0(RESULT_nP_0),
    .RESULT_1(RESULT_1), .INV_RESULT(INV_RESULT), .RESULT_INV_Cin(RESULT_INV_Cin),
    .RESULT_INV_Cout(RESULT_INV_Cout), .STORE_QUOT(STORE_QUOT), .Quotient(Quotient)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_acc"}, dut.ACC_Q, 1'b0);
    chk({tag, "_divl"}, DIVL_1, 1'b0);
    chk({tag, "_divh1"}, DIVH_1, 1'b0);
    chk({tag, "_divh0"}, DIVH_0, 1'b1);
    chk({tag, "_result"}, RESULT_1, 1'b0);
    chk({tag, "_quot"}, Quotient, 1'b0);
    chk({tag, "_rem"}, Remainder, 1'b0);
  endtask

  initial begin
    #12;
    chk_reset("reset");
    nReset = 1'b1;
    tick();
    chk_reset("idle");
    // divisor path
    DIVH_P = 1'b1; tick();
    chk("divh_shift", DIVH_1, 1'b1);
    chk("divh0_shift", DIVH_0, 1'b0);
    LOAD_DIVH = 1'b1; Operand2 = 1'b0; tick();
    chk("divh_load0", DIVH_1, 1'b0);
    chk("divh0_load0", DIVH_0, 1'b1);
    INV_OP2 = 1'b1; tick();
    chk("divh_inv", DIVH_1, 1'b1);
    OP2_INV_Cin = 1'b1; #1;
    chk("op2_cout", OP2_INV_Cout, 1'b1);
    tick();
    chk("divh_neg", DIVH_1, 1'b0);
    chk("divh0_neg", DIVH_0, 1'b1);
    // result register
    RESULT_P = 1'b1; tick();
    chk("result_p", RESULT_1, 1'b1);
    RESULT_nP_0 = 1'b1; tick();
    chk("result_force0", RESULT_1, 1'b0);
    RESULT_nP_0 = 1'b0; tick();
    chk("result_release", RESULT_1, 1'b1);
    // quotient latency and negation
    STORE_QUOT = 1'b1; tick();
    chk("quot_store", Quotient, 1'b1);
    RESULT_P = 1'b0; tick();
    chk("quot_lat1", Quotient, 1'b1);
    tick();
    chk("quot_lat2", Quotient, 1'b0);
    INV_RESULT = 1'b1; tick();
    chk("quot_inv", Quotient, 1'b1);
    RESULT_INV_Cin = 1'b1; #1;
    chk("res_cout1", RESULT_INV_Cout, 1'b1);
    tick();
    chk("quot_neg0", Quotient, 1'b0);
    RESULT_P = 1'b1; tick();
    chk("res_cout0", RESULT_INV_Cout, 1'b0);
    tick();
    chk("quot_neg1", Quotient, 1'b1);
    INV_RESULT = 1'b0; RESULT_INV_Cin = 1'b0;
    // store enable hold
    STORE_QUOT = 1'b0; RESULT_P = 1'b0; tick(); tick();
    chk("quot_hold", Quotient, 1'b1);
    chk("quot_hold_res", RESULT_1, 1'b0);
    STORE_QUOT = 1'b1; tick();
    chk("quot_reenable", Quotient, 1'b0);
    // accumulator, adder and remainder
    LOAD_ACC = 1'b1; STORE_ACC = 1'b1; Operand1 = 1'b0; tick();
    chk("acc_load0", dut.ACC_Q, 1'b0);
    Operand1 = 1'b1; tick();
    chk("acc_load1", dut.ACC_Q, 1'b1);
    LOAD_ACC = 1'b0; DIVH_0_P = 1'b1; ACC_Cin = 1'b1; #1;
    chk("acc_cout", ACC_Cout, 1'b1);
    tick();
    chk("acc_sum", dut.ACC_Q, 1'b1);
    STORE_ACC = 1'b0; DIVH_0_P = 1'b0; ACC_Cin = 1'b0;
    STORE_REM = 1'b1; INV_REM = 1'b1; tick();
    chk("rem_inv1", Remainder, 1'b0);
    LOAD_ACC = 1'b1; STORE_ACC = 1'b1; Operand1 = 1'b0; tick();
    chk("acc_reload0", dut.ACC_Q, 1'b0);
    tick();
    chk("rem_inv0", Remainder, 1'b1);
    STORE_ACC = 1'b0; Operand1 = 1'b1; tick();
    chk("acc_hold", dut.ACC_Q, 1'b0);
    STORE_REM = 1'b0; INV_REM = 1'b0; LOAD_ACC = 1'b0;
    // low dividend
    LOAD_DIVL = 1'b0; DIVL_P = 1'b1; tick();
    chk("divl_shift", DIVL_1, 1'b1);
    LOAD_DIVL = 1'b1; Operand1 = 1'b0; tick();
    chk("divl_load0", DIVL_1, 1'b0);
    // scan chain: six stages, first bit emerges on Remainder after six shifts
    Test = 1'b1; STORE_QUOT = 1'b0;
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      SDI = pat[i];
      sb.push_back(pat[i]);
      tick();
    end
    SDI = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL scan_sb_empty observed=0 expected=1");
      end else chk($sformatf("scan_bit%0d", i), Remainder, sb.pop_front());
      if (i < 5) tick();
    end
    // asynchronous reset mid-shift
    SDI = 1'b1; tick(); tick(); tick();
    #2 nReset = 1'b0; #1;
    chk_reset("async_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_bitslice.md
Name: div_bitslice

Overview:
- One-bit slice of a bit-serial/array integer divider datapath. N copies are abutted to form an N-bit divider.
- Each slice holds one bit of each register: accumulator (ACC), low dividend (DIVL), divisor (DIVH), result shift register (RESULT), quotient output (Quotient) and remainder output (Remainder).
- It also contains conditional two's-complement negator cells, chained through Cin/Cout, and a ripple-carry full adder.
- All registers are on a scan chain.

Parameters:
- None.

Ports:
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset, clears all registers
- Test  in  1  scan mode enable
- SDI  in  1  scan data in
- Operand1  in  1  operand 1 bit
- Operand2  in  1  operand 2 bit
- INV_OP1, INV_OP2  in  1  invert-select for the OP1 / OP2 negators
- OP1_INV_Cin, OP2_INV_Cin  in  1  negator carry in
- OP1_INV_Cout, OP2_INV_Cout  out  1  negator carry out
- DIVL_P  in  1  DIVL shift-in from neighbour slice
- LOAD_DIVL  in  1  DIVL load select
- DIVL_1  out  1  DIVL register bit
- DIVH_P  in  1  DIVH shift-in from neighbour slice
- LOAD_DIVH  in  1  DIVH load select
- DIVH_1  out  1  DIVH register bit
- DIVH_0  out  1  complement of DIVH_1
- DIVH_0_P  in  1  adder B operand (complemented divisor bit from neighbour)
- ACC_Cin  in  1  adder carry in
- ACC_Cout  out  1  adder carry out
- LOAD_ACC  in  1  ACC load select
- STORE_ACC  in  1  ACC write enable
- INV_REM  in  1  remainder negator invert-select
- ACC_INV_Cin  in  1  remainder negator carry in
- ACC_INV_Cout  out  1  remainder negator carry out
- STORE_REM  in  1  Remainder write enable
- Remainder  out  1  remainder bit; also scan out
- RESULT_P  in  1  RESULT shift-in
- RESULT_nP_0  in  1  force RESULT to 0
- RESULT_1  out  1  RESULT register bit
- INV_RESULT  in  1  result negator invert-select
- RESULT_INV_Cin  in  1  result negator carry in
- RESULT_INV_Cout  out  1  result negator carry out
- STORE_QUOT  in  1  Quotient write enable
- Quotient  out  1  quotient bit

Behaviour:
- Negator cell (combinational), with inputs a, inv, cin:
  - x = a ^ inv
  - sum = x ^ cin
  - cout = x & cin
  - OP1 negator: a = Operand1. OP2 negator: a = Operand2. REM negator: a = ACC_Q. RES negator: a = RESULT_1.
- Adder (combinational):
  - s = ACC_Q ^ DIVH_0_P ^ ACC_Cin
  - ACC_Cout = majority(ACC_Q, DIVH_0_P, ACC_Cin)
- Registers, updated on the rising Clock edge when Test = 0:
  - DIVL <= LOAD_DIVL ? OP1neg.sum : DIVL_P
  - DIVH <= LOAD_DIVH ? OP2neg.sum : DIVH_P
  - ACC (internal ACC_Q) <= LOAD_ACC ? OP1neg.sum : s, only when STORE_ACC = 1; otherwise it holds
  - RESULT <= RESULT_nP_0 ? 0 : RESULT_P
  - Quotient <= RESneg.sum when STORE_QUOT = 1; otherwise it holds
  - Remainder <= REMneg.sum when STORE_REM = 1; otherwise it holds
- Outputs: DIVL_1 = DIVL, DIVH_1 = DIVH, DIVH_0 = ~DIVH, RESULT_1 = RESULT.
- Latency:
  - Quotient reflects a RESULT_P change after 2 clocks (one for RESULT, one for Quotient).
  - All Cout outputs are purely combinational, with zero latency.
- Scan (Test = 1): every register ignores its functional D and enable and shifts in this order: SDI -> ACC -> DIVL -> DIVH -> RESULT -> Quotient -> Remainder. Remainder is the scan out.
- Reset (asynchronous, any time, including mid-operation): all registers go to 0. Hence DIVL_1, DIVH_1, RESULT_1, Quotient and Remainder are 0, and DIVH_0 = 1.
- Simultaneous controls: RESULT_nP_0 overrides RESULT_P. LOAD_x selects the load source but has no effect on the hold/enable function. Test overrides all functional controls.
- ACC_Q is an internal signal exposed under that name for hierarchical probing.

Decomposition:
- No shared package; no typedefs or constants required.
- One sub-module, div_neg_cell (XOR plus half adder), instantiated four times (OP1, OP2, REM, RES). The full adder and registers are inline.

Test Plan:
- DIVH path:
  - Reset with all inputs at 0 -> DIVH_1 = 0, DIVH_0 = 1.
  - DIVH_P = 1, one clock -> DIVH_1 = 1.
  - LOAD_DIVH = 1, Operand2 = 0 -> DIVH_1 = 0.
  - INV_OP2 = 1 -> DIVH_1 = 1.
  - OP2_INV_Cin = 1 -> DIVH_1 = 0, OP2_INV_Cout = 1.
  - DIVH_0 = ~DIVH_1 throughout.
- RESULT:
  - RESULT_P = 1 -> RESULT_1 = 1 after one clock.
  - RESULT_nP_0 = 1 -> RESULT_1 = 0.
  - Release RESULT_nP_0 -> RESULT_1 = 1.
- Quotient:
  - STORE_QUOT = 1 -> Quotient = RESULT_1 (2 clocks after a RESULT_P change).
  - INV_RESULT = 1 -> Quotient = ~RESULT_1.
  - Additionally RESULT_INV_Cin = 1 with RESULT_1 = 0 -> RESULT_INV_Cout = 1 and Quotient = 0.
  - With RESULT_1 = 1 -> RESULT_INV_Cout = 0 and Quotient = 1.
- Store enable:
  - Quotient = 1, STORE_QUOT = 0, RESULT driven to 0 for 2 clocks -> Quotient stays 1.
  - STORE_QUOT = 1 -> Quotient = 0 next clock.
- ACC and remainder:
  - LOAD_ACC = STORE_ACC = 1, Operand1 = 0 then 1 -> ACC_Q = 0 then 1.
  - LOAD_ACC = 0, DIVH_0_P = 1, ACC_Cin = 1 -> ACC_Cout = 1, ACC_Q = 1.
  - STORE_REM = 1, INV_REM = 1 -> Remainder = ~ACC_Q (with ACC_INV_Cin = 0).
- DIVL and scan:
  - LOAD_DIVL = 0, DIVL_P = 1 -> DIVL_1 = 1.
  - LOAD_DIVL = 1, Operand1 = 0 -> DIVL_1 = 0.
  - Test = 1, shift the pattern 1,0,1,1,0,1 in on SDI -> the pattern appears on Remainder in order after 6 clocks.
  - nReset pulse mid-shift -> all outputs 0 and DIVH_0 = 1 immediately.
